sliding_window_buffer: RTL and testbench

//   Holds one TILE x TILE tile of pixels and presents a KERN x KERN window from it.
//   The window raster-scans all (TILE-KERN+1)^2 positions, advancing one step per calc_done.
//   A shadow bank lets the loader preload the next tile while the convolution stage

---
 rtl/sliding_window_buffer_if.sv | 36 +++
 rtl/sliding_window_buffer.sv | 130 +++++++++++++
 tb/tb_sliding_window_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sliding_window_buffer_if.sv
// Bus between the pixel loader / convolution stage and the sliding window buffer.
// Handshake: the loader may drive load_enable with input_pixels whenever it likes; the
// tile is taken at the rising edge only if load_ready was 1 in that cycle, otherwise
// it is dropped. calc_done advances the window at the edge only if window_valid was 1
// in that cycle. tile_done is a one-cycle pulse, seen the cycle after the last window
// of a tile was consumed.
interface sliding_window_buffer_if #(
   parameter int PIX_W = 4,
   parameter int TILE  = 4,
   parameter int KERN  = 3
);
   localparam int NPOS  = TILE - KERN + 1;
   localparam int IDX_W = (NPOS > 1) ? $clog2(NPOS) : 1;

   logic                                 load_enable;
   logic [TILE-1:0][TILE-1:0][PIX_W-1:0] input_pixels;
   logic                                 calc_done;
   logic [KERN-1:0][KERN-1:0][PIX_W-1:0] output_pixels;
   logic                                 window_valid;
   logic                                 load_ready;
   logic [IDX_W-1:0]                     row_idx;
   logic [IDX_W-1:0]                     col_idx;
   logic                                 tile_done;

   // Loader / consumer side.
   modport master (
      output load_enable, input_pixels, calc_done,
      input  output_pixels, window_valid, load_ready, row_idx, col_idx, tile_done
   );

   // Buffer side.
   modport slave (
      input  load_enable, input_pixels, calc_done,
      output output_pixels, window_valid, load_ready, row_idx, col_idx, tile_done
   );
endinterface

// File: rtl/sliding_window_buffer.sv
// Double-banked tile buffer presenting a KERN x KERN window that raster-scans a
// TILE x TILE tile. The shadow bank takes the next tile while the active one is
// consumed; the swap happens on the edge that consumes the last window.
module sliding_window_buffer #(
   parameter int PIX_W = 4,
   parameter int TILE  = 4,
   parameter int KERN  = 3
) (
   input  logic                 clk,
   input  logic                 n_rst,
   sliding_window_buffer_if.slave bus,
   output logic [1:0]           state_dbg
);
   localparam int NPOS  = TILE - KERN + 1;
   localparam int IDX_W = (NPOS > 1) ? $clog2(NPOS) : 1;
   localparam int TW    = (TILE > 1) ? $clog2(TILE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOS - 1);

   typedef logic [TILE-1:0][TILE-1:0][PIX_W-1:0] tile_t;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      ACTIVE  = 2'd1,
      PENDING = 2'd2
   } state_t;

   state_t           state_q, state_d;
   tile_t            active_q, active_d;
   tile_t            shadow_q, shadow_d;
   logic [IDX_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic             tile_done_q, tile_done_d;

   logic             win_valid;
   logic             advance;
   logic [TW-1:0]    r_sel;
   logic [TW-1:0]    c_sel;

   assign win_valid = (state_q != EMPTY);
   assign advance   = bus.calc_done && win_valid;

   // State, banks and window position registers.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= EMPTY;
         active_q    <= '0;
         shadow_q    <= '0;
         row_q       <= '0;
         col_q       <= '0;
         tile_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         shadow_q    <= shadow_d;
         row_q       <= row_d;
         col_q       <= col_d;
         tile_done_q <= tile_done_d;
      end
   end

   // Next state: loads first, then the window advance; the swap only looks at state_q,
   // so a load landing in the same cycle as a swap in PENDING is simply dropped.
   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      shadow_d    = shadow_q;
      row_d       = row_q;
      col_d       = col_q;
      tile_done_d = 1'b0;

      case (state_q)
         EMPTY: begin
            if (bus.load_enable) begin
               active_d = bus.input_pixels;
               state_d  = ACTIVE;
               row_d    = '0;
               col_d    = '0;
            end
         end
         ACTIVE: begin
            if (bus.load_enable) begin
               shadow_d = bus.input_pixels;
               state_d  = PENDING;
            end
         end
         default: ;
      endcase

      if (advance) begin
         if (col_q != LAST_IDX) begin
            col_d = col_q + 1'b1;
         end else begin
            col_d = '0;
            if (row_q != LAST_IDX) begin
               row_d = row_q + 1'b1;
            end else begin
               row_d       = '0;
               tile_done_d = 1'b1;
               if (state_q == PENDING) begin
                  active_d = shadow_q;
                  state_d  = ACTIVE;
               end
            end
         end
      end
   end

   // Window extraction straight from the active bank; forced to zero with no tile.
   always_comb begin
      bus.output_pixels = '0;
      r_sel             = '0;
      c_sel             = '0;
      if (win_valid) begin
         for (int i = 0; i < KERN; i++) begin
            for (int j = 0; j < KERN; j++) begin
               r_sel = TW'(row_q) + TW'(i);
               c_sel = TW'(col_q) + TW'(j);
               bus.output_pixels[i][j] = active_q[r_sel][c_sel];
            end
         end
      end
   end

   assign bus.window_valid = win_valid;
   assign bus.load_ready   = (state_q != PENDING);
   assign bus.row_idx      = row_q;
   assign bus.col_idx      = col_q;
   assign bus.tile_done    = tile_done_q;
   assign state_dbg        = state_q;
endmodule

// File: tb/tb_sliding_window_buffer.sv
// Directed bench for sliding_window_buffer with PIX_W=4, TILE=4, KERN=3.
module tb_sliding_window_buffer;
   localparam int PIX_W = 4;
   localparam int TILE  = 4;
   localparam int KERN  = 3;

   typedef logic [TILE-1:0][TILE-1:0][PIX_W-1:0] tile_t;
   typedef logic [KERN-1:0][KERN-1:0][PIX_W-1:0] win_t;

   logic       clk;
   logic       n_rst;
   logic [1:0] state_dbg;
   int         checks;
   int         errors;
   tile_t      tile_a;
   tile_t      tile_b;
   win_t       win_obs;

   sliding_window_buffer_if #(.PIX_W(PIX_W), .TILE(TILE), .KERN(KERN)) bus ();

   sliding_window_buffer #(.PIX_W(PIX_W), .TILE(TILE), .KERN(KERN)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected window at (r,c) of a tile.
   function automatic win_t exp_win(input tile_t t, input int r, input int c);
      win_t w;
      w = '0;
      for (int i = 0; i < KERN; i++)
         for (int j = 0; j < KERN; j++)
            w[i][j] = t[r+i][c+j];
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One edge; outputs are sampled 1 time unit after it, inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pos(input string tag, input int r, input int c, input int p00);
      win_obs = bus.output_pixels;
      chk({tag, "_row"}, 64'(bus.row_idx), 64'(r));
      chk({tag, "_col"}, 64'(bus.col_idx), 64'(c));
      chk({tag, "_p00"}, 64'(win_obs[0][0]), 64'(p00));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int r = 0; r < TILE; r++)
         for (int c = 0; c < TILE; c++) begin
            tile_a[r][c] = 4'(r * 4 + c);
            tile_b[r][c] = 4'(15 - (r * 4 + c));
         end

      // 1: reset then idle
      n_rst = 1'b0;
      bus.load_enable = 1'b0;
      bus.calc_done = 1'b0;
      bus.input_pixels = '0;
      tick();
      tick();
      n_rst = 1'b1;
      tick();
      chk("rst_out", 64'(bus.output_pixels), 64'd0);
      chk("rst_valid", 64'(bus.window_valid), 64'd0);
      chk("rst_ready", 64'(bus.load_ready), 64'd1);
      chk("rst_done", 64'(bus.tile_done), 64'd0);
      chk("rst_state", 64'(state_dbg), 64'd0);

      // 2: load A in EMPTY
      bus.input_pixels = tile_a;
      bus.load_enable = 1'b1;
      tick();
      bus.load_enable = 1'b0;
      bus.input_pixels = '0;
      win_obs = bus.output_pixels;
      chk("a_valid", 64'(bus.window_valid), 64'd1);
      chk_pos("a_load", 0, 0, 0);
      chk("a_p22", 64'(win_obs[2][2]), 64'd10);
      chk("a_ready", 64'(bus.load_ready), 64'd1);
      chk("a_win00", 64'(bus.output_pixels), 64'(exp_win(tile_a, 0, 0)));

      // 3: full scan of A, then wrap
      bus.calc_done = 1'b1;
      tick();
      chk_pos("scan1", 0, 1, 1);
      tick();
      chk_pos("scan2", 1, 0, 4);
      chk("scan2_win", 64'(bus.output_pixels), 64'(exp_win(tile_a, 1, 0)));
      tick();
      chk_pos("scan3", 1, 1, 5);
      chk("scan3_done", 64'(bus.tile_done), 64'd0);
      tick();
      bus.calc_done = 1'b0;
      chk("wrap_done", 64'(bus.tile_done), 64'd1);
      chk_pos("wrap", 0, 0, 0);
      tick();
      chk("wrap_done_pulse", 64'(bus.tile_done), 64'd0);

      // 4: load B while ACTIVE at (0,1), second load ignored, swap on last position
      bus.calc_done = 1'b1;
      tick();
      bus.calc_done = 1'b0;
      chk_pos("pre_b", 0, 1, 1);
      bus.input_pixels = tile_b;
      bus.load_enable = 1'b1;
      tick();
      chk("b_ready", 64'(bus.load_ready), 64'd0);
      chk("b_state", 64'(state_dbg), 64'd2);
      chk_pos("b_hold", 0, 1, 1);
      bus.input_pixels = '0;
      tick();
      bus.load_enable = 1'b0;
      chk_pos("b_ignored", 0, 1, 1);
      chk("b_ready2", 64'(bus.load_ready), 64'd0);
      bus.calc_done = 1'b1;
      tick();
      tick();
      chk_pos("b_pend", 1, 1, 5);
      tick();
      bus.calc_done = 1'b0;
      win_obs = bus.output_pixels;
      chk("swap_done", 64'(bus.tile_done), 64'd1);
      chk_pos("swap", 0, 0, 15);
      chk("swap_p22", 64'(win_obs[2][2]), 64'd5);
      chk("swap_ready", 64'(bus.load_ready), 64'd1);
      chk("swap_win", 64'(bus.output_pixels), 64'(exp_win(tile_b, 0, 0)));

      // 5: calc_done in EMPTY is ignored; load + last-position calc_done in ACTIVE
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      bus.calc_done = 1'b1;
      tick();
      tick();
      bus.calc_done = 1'b0;
      chk("empty_valid", 64'(bus.window_valid), 64'd0);
      chk("empty_out", 64'(bus.output_pixels), 64'd0);
      chk("empty_done", 64'(bus.tile_done), 64'd0);
      chk("empty_row", 64'(bus.row_idx), 64'd0);
      chk("empty_col", 64'(bus.col_idx), 64'd0);
      bus.input_pixels = tile_a;
      bus.load_enable = 1'b1;
      tick();
      bus.load_enable = 1'b0;
      bus.calc_done = 1'b1;
      tick();
      tick();
      tick();
      chk_pos("sim_pre", 1, 1, 5);
      chk("sim_pre_state", 64'(state_dbg), 64'd1);
      bus.input_pixels = tile_b;
      bus.load_enable = 1'b1;
      tick();
      bus.load_enable = 1'b0;
      bus.calc_done = 1'b0;
      bus.input_pixels = '0;
      chk("sim_done", 64'(bus.tile_done), 64'd1);
      chk_pos("sim_wrap", 0, 0, 0);
      chk("sim_state", 64'(state_dbg), 64'd2);
      chk("sim_ready", 64'(bus.load_ready), 64'd0);

      // 6: reset in PENDING at (1,1) drops the shadow tile
      bus.calc_done = 1'b1;
      tick();
      tick();
      tick();
      chk_pos("p_pre", 1, 1, 5);
      chk("p_pre_state", 64'(state_dbg), 64'd2);
      n_rst = 1'b0;
      bus.load_enable = 1'b1;
      bus.input_pixels = tile_b;
      tick();
      n_rst = 1'b1;
      bus.load_enable = 1'b0;
      bus.calc_done = 1'b0;
      bus.input_pixels = '0;
      chk("p_rst_out", 64'(bus.output_pixels), 64'd0);
      chk("p_rst_valid", 64'(bus.window_valid), 64'd0);
      chk("p_rst_ready", 64'(bus.load_ready), 64'd1);
      chk("p_rst_done", 64'(bus.tile_done), 64'd0);
      chk("p_rst_row", 64'(bus.row_idx), 64'd0);
      chk("p_rst_col", 64'(bus.col_idx), 64'd0);
      tick();
      bus.input_pixels = tile_a;
      bus.load_enable = 1'b1;
      tick();
      bus.load_enable = 1'b0;
      bus.input_pixels = '0;
      chk_pos("reload", 0, 0, 0);
      chk("reload_win", 64'(bus.output_pixels), 64'(exp_win(tile_a, 0, 0)));
      bus.calc_done = 1'b1;
      tick();
      tick();
      tick();
      tick();
      bus.calc_done = 1'b0;
      chk("rescan_done", 64'(bus.tile_done), 64'd1);
      chk_pos("rescan", 0, 0, 0);
      chk("rescan_state", 64'(state_dbg), 64'd1);
      chk("rescan_ready", 64'(bus.load_ready), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
